// File: rtl/expr_lane_pkg.sv
// Shared opcode enum and elaboration limits for the expression lane pipe.
package expr_lane_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_XOR = 3'd3,
        OP_SHL = 3'd4,
        OP_SHR = 3'd5,
        OP_LT  = 3'd6,
        OP_EQ  = 3'd7
    } op_e;

    localparam int MAX_NLANES = 16;
    localparam int MAX_W      = 32;
    localparam int MAX_DEPTH  = 4;

endpackage

// File: rtl/expr_lane_alu.sv
// One combinational lane: mixed-signedness ALU with overflow/borrow flag.
// Build option EXPR_LANE_PIPE_SAT_EN makes ADD/SUB saturate on overflow.
module expr_lane_alu
    import expr_lane_pkg::*;
#(
    parameter int W = 6
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sgn,
    input  op_e          i_op,
    output logic [W-1:0] o_y,
    output logic         o_flag
);

`ifdef EXPR_LANE_PIPE_SAT_EN
    localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
`endif

    logic [W:0]   w_ax;
    logic [W:0]   w_bx;
    logic [W:0]   w_sum;
    logic [W:0]   w_dif;
    logic         w_ovf_add;
    logic         w_ovf_sub;
    logic         w_big;
    logic         w_lt;
    logic [W-1:0] w_shl;
    logic [W-1:0] w_srl;
    logic [W-1:0] w_sra;
    logic [W-1:0] w_fill;

    // W+1-bit extension makes carry, borrow and signed overflow all visible
    assign w_ax  = {i_sgn & i_a[W-1], i_a};
    assign w_bx  = {i_sgn & i_b[W-1], i_b};
    assign w_sum = w_ax + w_bx;
    assign w_dif = w_ax - w_bx;

    assign w_ovf_add = i_sgn ? (w_sum[W] ^ w_sum[W-1]) : w_sum[W];
    assign w_ovf_sub = i_sgn ? (w_dif[W] ^ w_dif[W-1]) : w_dif[W];

    assign w_big  = 32'(i_b) >= 32'(W);
    assign w_shl  = i_a << i_b;
    assign w_srl  = i_a >> i_b;
    assign w_sra  = $signed(i_a) >>> i_b;
    assign w_fill = {W{i_sgn & i_a[W-1]}};
    assign w_lt   = $signed(w_ax) < $signed(w_bx);

    always_comb begin
        o_y    = '0;
        o_flag = 1'b0;
        unique case (i_op)
            OP_ADD: begin
                o_y    = w_sum[W-1:0];
                o_flag = w_ovf_add;
`ifdef EXPR_LANE_PIPE_SAT_EN
                if (w_ovf_add)
                    o_y = i_sgn ? (w_sum[W] ? SMIN : SMAX) : '1;
`endif
            end
            OP_SUB: begin
                o_y    = w_dif[W-1:0];
                o_flag = w_ovf_sub;
`ifdef EXPR_LANE_PIPE_SAT_EN
                if (w_ovf_sub)
                    o_y = i_sgn ? (w_dif[W] ? SMIN : SMAX) : '0;
`endif
            end
            OP_AND: o_y = i_a & i_b;
            OP_XOR: o_y = i_a ^ i_b;
            OP_SHL: o_y = w_big ? '0 : w_shl;
            OP_SHR: o_y = w_big ? w_fill : (i_sgn ? w_sra : w_srl);
            OP_LT:  o_y = {{(W-1){1'b0}}, w_lt};
            OP_EQ:  o_y = {{(W-1){1'b0}}, i_a == i_b};
        endcase
    end

endmodule

// File: rtl/expr_lane_pipe.sv
// NLANES-wide expression ALU behind a DEPTH-stage valid/ready pipeline.
// Build option EXPR_LANE_PIPE_SAT_EN selects saturating ADD/SUB in every lane.
module expr_lane_pipe
    import expr_lane_pkg::*;
#(
    parameter int NLANES = 6,
    parameter int W      = 6,
    parameter int DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_W-1:0]       op,
    input  logic [NLANES-1:0]     sgn,
    input  logic [NLANES*W-1:0]   a,
    input  logic [NLANES*W-1:0]   b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NLANES*W-1:0]   y,
    output logic [NLANES-1:0]     flags
);

    if (NLANES < 1 || NLANES > MAX_NLANES) begin : g_bad_nlanes
        $error("expr_lane_pipe: NLANES out of range");
    end
    if (W < 2 || W > MAX_W) begin : g_bad_w
        $error("expr_lane_pipe: W out of range");
    end
    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $error("expr_lane_pipe: DEPTH out of range");
    end

    logic [NLANES*W-1:0] w_y;
    logic [NLANES-1:0]   w_f;
    logic [DEPTH-1:0]    w_adv;

    logic [DEPTH-1:0]    r_vld;
    logic [NLANES*W-1:0] r_y [DEPTH];
    logic [NLANES-1:0]   r_f [DEPTH];

    // Lane 0 occupies the most significant slice of the packed buses
    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        expr_lane_alu #(.W(W)) u_alu (
            .i_a    (a[(NLANES-1-i)*W +: W]),
            .i_b    (b[(NLANES-1-i)*W +: W]),
            .i_sgn  (sgn[i]),
            .i_op   (op_e'(op)),
            .o_y    (w_y[(NLANES-1-i)*W +: W]),
            .o_flag (w_f[i])
        );
    end

    always_comb begin
        w_adv = '0;
        w_adv[DEPTH-1] = !r_vld[DEPTH-1] || out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            w_adv[k] = !r_vld[k] || w_adv[k+1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_y[k] <= '0;
                r_f[k] <= '0;
            end
        end else begin
            if (w_adv[0]) begin
                r_vld[0] <= in_valid;
                if (in_valid) begin
                    r_y[0] <= w_y;
                    r_f[0] <= w_f;
                end
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (w_adv[k]) begin
                    r_vld[k] <= r_vld[k-1];
                    if (r_vld[k-1]) begin
                        r_y[k] <= r_y[k-1];
                        r_f[k] <= r_f[k-1];
                    end
                end
            end
        end
    end

    assign in_ready  = w_adv[0];
    assign out_valid = r_vld[DEPTH-1];
    assign y         = r_y[DEPTH-1];
    assign flags     = r_f[DEPTH-1];

endmodule

// File: tb/tb_expr_lane_pipe.sv
// Bench for expr_lane_pipe: directed vectors, backpressure/reset sequences, random vs model.
module tb_expr_lane_pipe;

    localparam int NL = 6;
    localparam int W  = 6;
    localparam int D  = 2;
    localparam int BW = NL * W;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [NL-1:0] sgn;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] y;
    logic [NL-1:0] flags;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    expr_lane_pipe #(.NLANES(NL), .W(W), .DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .sgn       (sgn),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .flags     (flags)
    );

    typedef struct {
        string      nm;
        int         lane;
        logic [2:0] op;
        logic       sg;
        logic [5:0] a;
        logic [5:0] b;
        logic [5:0] ey;
        logic       ef;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    endtask

    function automatic logic [BW-1:0] rep(input int v);
        logic [BW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*W +: W] = 6'(v);
        return r;
    endfunction

    function automatic vec_t mk(input string nm, input int lane, input int o, input int s,
                                input int va, input int vb, input int ey, input int ef);
        vec_t v;
        v.nm = nm; v.lane = lane; v.op = 3'(o); v.sg = 1'(s);
        v.a = 6'(va); v.b = 6'(vb); v.ey = 6'(ey); v.ef = 1'(ef);
        return v;
    endfunction

    // Reference: each lane evaluated with plain integer arithmetic on its true value
    function automatic void model(input logic [2:0] o, input logic [NL-1:0] s,
                                  input logic [BW-1:0] aa, input logic [BW-1:0] bb,
                                  output logic [BW-1:0] ry, output logic [NL-1:0] rf);
        int ua, ub, va, vb, r, res;
        bit ovf;
        ry = '0;
        rf = '0;
        for (int i = 0; i < NL; i++) begin
            ua = int'(aa[(NL-1-i)*W +: W]);
            ub = int'(bb[(NL-1-i)*W +: W]);
            va = (s[i] && ua >= 32) ? ua - 64 : ua;
            vb = (s[i] && ub >= 32) ? ub - 64 : ub;
            ovf = 0;
            res = 0;
            case (o)
                3'd0: begin
                    r = va + vb;
                    ovf = s[i] ? (r > 31 || r < -32) : (r > 63);
                    res = r;
`ifdef EXPR_LANE_PIPE_SAT_EN
                    if (ovf) res = s[i] ? (r > 0 ? 31 : -32) : 63;
`endif
                end
                3'd1: begin
                    r = va - vb;
                    ovf = s[i] ? (r > 31 || r < -32) : (r < 0);
                    res = r;
`ifdef EXPR_LANE_PIPE_SAT_EN
                    if (ovf) res = s[i] ? (r > 0 ? 31 : -32) : 0;
`endif
                end
                3'd2: res = ua & ub;
                3'd3: res = ua ^ ub;
                3'd4: res = (ub >= W) ? 0 : (ua << ub);
                3'd5: res = s[i] ? (va >>> ub) : ((ub >= W) ? 0 : (ua >> ub));
                3'd6: res = (va < vb) ? 1 : 0;
                default: res = (ua == ub) ? 1 : 0;
            endcase
            ry[(NL-1-i)*W +: W] = 6'(res);
            rf[i] = ovf;
        end
    endfunction

    task automatic run_vec(input vec_t v);
        int lat;
        op = v.op;
        sgn = '0;
        sgn[v.lane] = v.sg;
        a = '0;
        b = '0;
        a[(NL-1-v.lane)*W +: W] = v.a;
        b[(NL-1-v.lane)*W +: W] = v.b;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk({v.nm, "_rdy"}, 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({v.nm, "_lat"}, 64'(lat), 64'(D));
        chk({v.nm, "_y"}, 64'(y[(NL-1-v.lane)*W +: W]), 64'(v.ey));
        chk({v.nm, "_flag"}, 64'(flags[v.lane]), 64'(v.ef));
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t vt[$];
        logic [BW+NL-1:0] q[$];
        logic [BW-1:0] ey, py;
        logic [NL-1:0] ef, pf;
        logic [BW+NL-1:0] got;
        int v, acc, ex, seen, maxq;
        bit rdy, hold;

        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        op = 3'd0; sgn = '0; a = rep(5); b = rep(1);

        // Reset held for two edges with data offered
        @(posedge clk); #1;
        chk("rst_ov", 64'(out_valid), 64'(0));
        chk("rst_y", 64'(y), 64'(0));
        chk("rst_flags", 64'(flags), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        in_valid = 1'b0;
        chk("rst_inrdy", 64'(in_ready), 64'(1));
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("rst_noout", 64'(seen), 64'(0));

`ifdef EXPR_LANE_PIPE_SAT_EN
        vt.push_back(mk("add_sovf", 0, 0, 1, 31, 1, 31, 1));
        vt.push_back(mk("sub_borrow", 1, 1, 0, 3, 5, 0, 1));
        vt.push_back(mk("add_carry", 5, 0, 0, 40, 30, 63, 1));
        vt.push_back(mk("sub_sovf", 5, 1, 1, 32, 1, 32, 1));
`else
        vt.push_back(mk("add_sovf", 0, 0, 1, 31, 1, 32, 1));
        vt.push_back(mk("sub_borrow", 1, 1, 0, 3, 5, 62, 1));
        vt.push_back(mk("add_carry", 5, 0, 0, 40, 30, 6, 1));
        vt.push_back(mk("sub_sovf", 5, 1, 1, 32, 1, 31, 1));
`endif
        vt.push_back(mk("shr_s", 2, 5, 1, 48, 2, 60, 0));
        vt.push_back(mk("shr_u", 2, 5, 0, 48, 2, 12, 0));
        vt.push_back(mk("shr_big", 2, 5, 1, 48, 9, 63, 0));
        vt.push_back(mk("lt_s", 3, 6, 1, 63, 1, 1, 0));
        vt.push_back(mk("lt_u", 3, 6, 0, 63, 1, 0, 0));
        vt.push_back(mk("eq", 3, 7, 0, 42, 42, 1, 0));
        vt.push_back(mk("shl_big", 4, 4, 0, 3, 6, 0, 0));
        vt.push_back(mk("shl", 4, 4, 0, 3, 2, 12, 0));
        vt.push_back(mk("xor", 1, 3, 1, 45, 15, 34, 0));
        foreach (vt[i]) run_vec(vt[i]);

        // Backpressure: stall output, then release and check ordered streaming
        op = 3'd0; sgn = '0; b = '0;
        v = 1; a = rep(v); in_valid = 1'b1; out_ready = 1'b0; acc = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            rdy = in_ready;
            if (c >= 2) chk("bp_rdy_low", 64'(in_ready), 64'(0));
            if (c >= 2) chk("bp_hold", 64'(y), 64'(rep(1)));
            if (c == 4) chk("bp_ov", 64'(out_valid), 64'(1));
            @(posedge clk); #1;
            if (rdy) begin acc++; v++; a = rep(v); end
        end
        chk("bp_accepts", 64'(acc), 64'(2));
        out_ready = 1'b1;
        ex = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("bp_valid", 64'(out_valid), 64'(1));
            chk("bp_order", 64'(y), 64'(rep(ex)));
            rdy = in_ready;
            @(posedge clk); #1;
            ex++;
            if (rdy) begin v++; a = rep(v); end
        end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ov", 64'(out_valid), 64'(0));
        chk("midrst_y", 64'(y), 64'(0));
        reset = 1'b0;
        in_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("midrst_noout", 64'(seen), 64'(0));

        // Random traffic against the reference model
        hold = 0; py = '0; pf = '0; maxq = 0;
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            op = 3'($urandom % 8);
            sgn = NL'($urandom);
            for (int i = 0; i < NL; i++) begin
                a[i*W +: W] = 6'($urandom_range(0, 63));
                b[i*W +: W] = ($urandom % 4 == 0) ? 6'($urandom_range(0, 63))
                                                  : 6'($urandom_range(0, 7));
            end
            @(negedge clk);
            if (hold) begin
                chk("rnd_stall_y", 64'(y), 64'(py));
                chk("rnd_stall_f", 64'(flags), 64'(pf));
            end
            if (in_valid && in_ready) begin
                model(op, sgn, a, b, ey, ef);
                q.push_back({ey, ef});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious", 64'(1), 64'(0));
                end else begin
                    got = q.pop_front();
                    chk("rnd_y", 64'(y), 64'(got[BW+NL-1:NL]));
                    chk("rnd_flags", 64'(flags), 64'(got[NL-1:0]));
                end
            end
            if (q.size() > maxq) maxq = q.size();
            hold = out_valid && !out_ready;
            py = y;
            pf = flags;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            @(negedge clk);
            if (out_valid) begin
                got = q.pop_front();
                chk("drain_y", 64'(y), 64'(got[BW+NL-1:NL]));
                chk("drain_flags", 64'(flags), 64'(got[NL-1:0]));
            end
            @(posedge clk); #1;
        end
        chk("drain_empty", 64'(q.size()), 64'(0));
        chk("inflight_max", 64'(maxq <= D), 64'(1));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
